// File: rtl/pixel_uart_pkg.sv
// Shared timing defaults, receiver state encoding and command payload
// for the pixel UART receiver.
package pixel_uart_pkg;

    localparam int unsigned CLKS_PER_BIT = 104;
    localparam int unsigned GAP_TIMEOUT  = 12000;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic [7:0] pos;
        logic [7:0] value;
    } pixel_cmd_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling,
// one-cycle byte strobe on a good stop bit and frame_err on a bad one.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = pixel_uart_pkg::CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic       start,
    output logic       strobe,
    output logic [7:0] data,
    output logic       frame_err
);
    import pixel_uart_pkg::*;

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             fall;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Synchronizer plus one history flop for falling-edge detection; idle is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev & ~rx_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            start     <= 1'b0;
            strobe    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            start     <= 1'b0;
            strobe    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        state <= RX_START;
                        cnt   <= '0;
                        start <= 1'b1;
                    end
                end
                RX_START: begin
                    // A line that is high again at mid start bit was only a glitch.
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            strobe <= 1'b1;
                            data   <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pixel_uart_rx.sv
// Pixel command receiver: pairs UART bytes into {pos, value}, drops a stale
// pos after an inter-byte gap, and hands commands to a busy-gated writer.
module pixel_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = pixel_uart_pkg::CLKS_PER_BIT,
    parameter int unsigned GAP_TIMEOUT  = pixel_uart_pkg::GAP_TIMEOUT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    input  logic       busy,
    output logic       valid,
    output logic [7:0] pos,
    output logic [7:0] value,
    output logic       frame_err,
    output logic       overflow
);
    import pixel_uart_pkg::*;

    localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

    logic             rx_start;
    logic             byte_strobe;
    logic [7:0]       byte_data;
    logic             expect_value;
    logic [7:0]       held_pos;
    logic             gap_run;
    logic [GAP_W-1:0] gap_cnt;
    logic             pending;
    logic             stash_full;
    pixel_cmd_t       stash;
    pixel_cmd_t       pair;
    logic             pair_done;
    logic             fire;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .CLK       (CLK),
        .RST       (RST),
        .RX        (RX),
        .start     (rx_start),
        .strobe    (byte_strobe),
        .data      (byte_data),
        .frame_err (frame_err)
    );

    assign pair_done = byte_strobe & expect_value;
    assign pair      = '{pos: held_pos, value: byte_data};
    assign fire      = pending & ~busy;

    // Framer: first byte is pos, second is value; gap timer guards the held pos.
    always_ff @(posedge CLK) begin
        if (RST) begin
            expect_value <= 1'b0;
            held_pos     <= '0;
            gap_run      <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            if (gap_run) begin
                if (rx_start) begin
                    gap_run <= 1'b0;
                end else if (gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
                    gap_run      <= 1'b0;
                    expect_value <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end
            if (frame_err) begin
                expect_value <= 1'b0;
                gap_run      <= 1'b0;
            end else if (byte_strobe) begin
                if (expect_value) begin
                    expect_value <= 1'b0;
                end else begin
                    held_pos     <= byte_data;
                    expect_value <= 1'b1;
                    gap_run      <= 1'b1;
                    gap_cnt      <= '0;
                end
            end
        end
    end

    // Pending command register drives pos/value directly; a pair that lands
    // while the old one is being issued waits one cycle in the stash.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid      <= 1'b0;
            overflow   <= 1'b0;
            pos        <= '0;
            value      <= '0;
            pending    <= 1'b0;
            stash_full <= 1'b0;
            stash      <= '0;
        end else begin
            valid    <= 1'b0;
            overflow <= 1'b0;
            if (fire) begin
                valid   <= 1'b1;
                pending <= 1'b0;
            end
            if (stash_full) begin
                pos        <= stash.pos;
                value      <= stash.value;
                pending    <= 1'b1;
                stash_full <= 1'b0;
            end
            if (pair_done) begin
                if (fire) begin
                    stash      <= pair;
                    stash_full <= 1'b1;
                end else if (pending) begin
                    overflow <= 1'b1;
                end else begin
                    pos   <= pair.pos;
                    value <= pair.value;
                    if (busy) begin
                        pending <= 1'b1;
                    end else begin
                        valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_uart_rx.sv
// Directed bench for pixel_uart_rx: table of back-to-back pairs plus
// hand-written busy, overflow, framing, glitch, gap and reset sequences.
module tb_pixel_uart_rx;

    localparam int CPB = 104;

    logic       CLK;
    logic       RST;
    logic       RX;
    logic       busy;
    logic       valid;
    logic [7:0] pos;
    logic [7:0] value;
    logic       frame_err;
    logic       overflow;

    pixel_uart_rx dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX        (RX),
        .busy      (busy),
        .valid     (valid),
        .pos       (pos),
        .value     (value),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_ovf   = 0;
    int         n_dbl   = 0;
    int         valid_cyc = 0;
    logic [7:0] got_pos = 8'h00;
    logic [7:0] got_val = 8'h00;
    logic       valid_prev = 1'b0;

    // Output monitor, sampled away from the active edge.
    always @(negedge CLK) begin
        if (valid) begin
            n_valid   = n_valid + 1;
            got_pos   = pos;
            got_val   = value;
            valid_cyc = cyc;
        end
        if (valid && valid_prev) n_dbl = n_dbl + 1;
        valid_prev = valid;
        if (frame_err) n_ferr = n_ferr + 1;
        if (overflow)  n_ovf  = n_ovf + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        RX = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            idle(CPB);
        end
        RX = stop_bit;
        idle(CPB);
        RX = 1'b1;
    endtask

    typedef struct {
        logic [7:0] p;
        logic [7:0] v;
        int         exp_cnt;
        logic [7:0] exp_pos;
        logic [7:0] exp_val;
    } vec_t;

    vec_t vecs[4];
    int   base_v;
    int   base_f;
    int   base_o;
    int   vstart;

    initial begin
        vecs[0] = '{8'hC3, 8'h5B, 1, 8'hC3, 8'h5B};
        vecs[1] = '{8'h00, 8'hFF, 1, 8'h00, 8'hFF};
        vecs[2] = '{8'hA5, 8'h3C, 1, 8'hA5, 8'h3C};
        vecs[3] = '{8'h80, 8'h01, 1, 8'h80, 8'h01};

        RST  = 1'b1;
        RX   = 1'b1;
        busy = 1'b0;
        idle(5);
        check("rst_valid", int'(valid), 0);
        check("rst_pos", int'(pos), 8'h00);
        check("rst_value", int'(value), 8'h00);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overflow", int'(overflow), 0);
        RST = 1'b0;
        idle(20);

        // Back-to-back pairs with busy low; valid one cycle after the second stop sample.
        for (int i = 0; i < 4; i++) begin
            base_v = n_valid;
            base_f = n_ferr;
            send_byte(vecs[i].p, 1'b1);
            vstart = cyc;
            send_byte(vecs[i].v, 1'b1);
            idle(60);
            check("vec_valid_count", n_valid - base_v, vecs[i].exp_cnt);
            check("vec_pos", int'(got_pos), int'(vecs[i].exp_pos));
            check("vec_value", int'(got_val), int'(vecs[i].exp_val));
            check("vec_frame_err", n_ferr - base_f, 0);
            check_range("vec_latency", valid_cyc - vstart, 988, 996);
        end

        // Busy held across the whole pair, then released.
        base_v = n_valid;
        busy = 1'b1;
        send_byte(8'hFF, 1'b1);
        send_byte(8'h89, 1'b1);
        idle(100);
        check("busy_no_valid", n_valid - base_v, 0);
        check("busy_pos_held", int'(pos), 8'hFF);
        check("busy_value_held", int'(value), 8'h89);
        busy = 1'b0;
        idle(5);
        check("busy_release_count", n_valid - base_v, 1);
        check("busy_release_pos", int'(got_pos), 8'hFF);
        check("busy_release_value", int'(got_val), 8'h89);
        idle(50);
        check("busy_single_fire", n_valid - base_v, 1);

        // Second pair while the first is still pending: dropped with overflow.
        base_v = n_valid;
        base_o = n_ovf;
        busy = 1'b1;
        send_byte(8'hC0, 1'b1);
        send_byte(8'h06, 1'b1);
        send_byte(8'hC1, 1'b1);
        send_byte(8'h5B, 1'b1);
        idle(100);
        check("ovf_count", n_ovf - base_o, 1);
        check("ovf_no_valid", n_valid - base_v, 0);
        check("ovf_pos_kept", int'(pos), 8'hC0);
        check("ovf_value_kept", int'(value), 8'h06);
        busy = 1'b0;
        idle(50);
        check("ovf_release_count", n_valid - base_v, 1);
        check("ovf_release_pos", int'(got_pos), 8'hC0);
        check("ovf_release_value", int'(got_val), 8'h06);

        // Bad stop bit on a pos byte, then a clean pair.
        base_v = n_valid;
        base_f = n_ferr;
        send_byte(8'hC2, 1'b0);
        idle(20);
        check("ferr_count", n_ferr - base_f, 1);
        send_byte(8'hC4, 1'b1);
        send_byte(8'h7F, 1'b1);
        idle(60);
        check("ferr_valid_count", n_valid - base_v, 1);
        check("ferr_pos", int'(got_pos), 8'hC4);
        check("ferr_value", int'(got_val), 8'h7F);

        // Short low glitch is rejected at the start-bit sample.
        base_v = n_valid;
        base_f = n_ferr;
        RX = 1'b0;
        idle(20);
        RX = 1'b1;
        idle(300);
        check("glitch_no_valid", n_valid - base_v, 0);
        check("glitch_no_ferr", n_ferr - base_f, 0);

        // Gap longer than the timeout discards the held pos byte.
        send_byte(8'hC5, 1'b1);
        idle(13000);
        send_byte(8'hC6, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(60);
        check("gap_valid_count", n_valid - base_v, 1);
        check("gap_pos", int'(got_pos), 8'hC6);
        check("gap_value", int'(got_val), 8'h01);

        // Gap shorter than the timeout keeps the pair together.
        base_v = n_valid;
        send_byte(8'h3A, 1'b1);
        idle(5000);
        send_byte(8'h9C, 1'b1);
        idle(60);
        check("short_gap_count", n_valid - base_v, 1);
        check("short_gap_pos", int'(got_pos), 8'h3A);
        check("short_gap_value", int'(got_val), 8'h9C);

        // Reset in the middle of the value byte's data bits.
        base_v = n_valid;
        send_byte(8'h12, 1'b1);
        RX = 1'b0;
        idle(CPB);
        RX = 1'b0;
        idle(CPB);
        RX = 1'b0;
        idle(CPB);
        RX = 1'b1;
        idle(CPB / 2);
        RST = 1'b1;
        RX  = 1'b1;
        idle(3);
        check("midrst_valid", int'(valid), 0);
        check("midrst_pos", int'(pos), 8'h00);
        check("midrst_value", int'(value), 8'h00);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_overflow", int'(overflow), 0);
        RST = 1'b0;
        idle(1500);
        check("midrst_no_valid", n_valid - base_v, 0);
        send_byte(8'hC7, 1'b1);
        send_byte(8'h11, 1'b1);
        idle(60);
        check("midrst_next_count", n_valid - base_v, 1);
        check("midrst_next_pos", int'(got_pos), 8'hC7);
        check("midrst_next_value", int'(got_val), 8'h11);

        check("valid_single_cycle", n_dbl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_uart_rx.md
PIXEL_UART_RX -- requirements
Module: pixel_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, means CLK cycles per UART bit (12 MHz / 115200).
REQ-002 Parameter GAP_TIMEOUT, default 12000, means the maximum CLK cycles from a pos-byte stop sample to the value-byte start edge (1 ms).
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 RX  input  1  asynchronous UART line, 8N1, idle high, LSB first.
REQ-006 busy  input  1  downstream pixel writer busy; high means do not present a command.
REQ-007 valid  output  1  single-cycle command strobe to the pixel writer.
REQ-008 pos  output  8  pixel/command position byte, stable whenever valid is high.
REQ-009 value  output  8  pixel data byte, stable whenever valid is high.
REQ-010 frame_err  output  1  single-cycle pulse when a stop bit samples low.
REQ-011 overflow  output  1  single-cycle pulse when a completed pair is dropped because a command is still pending.

Function
REQ-012 RX SHALL pass through a 2-flop synchronizer before any use; the synchronizer adds 2 cycles of latency.
REQ-013 The byte receiver SHALL use states IDLE, START, DATA, STOP.
REQ-014 IDLE->START on a synchronized high-to-low transition; START counts CLKS_PER_BIT/2 cycles, then samples RX.
REQ-015 At the START sample, low -> DATA; high -> IDLE with no output (glitch reject).
REQ-016 DATA samples 8 bits at CLKS_PER_BIT intervals into bit 0 first, then -> STOP.
REQ-017 STOP samples after CLKS_PER_BIT; high -> byte accepted (1-cycle internal strobe); low -> frame_err pulse, byte discarded; both -> IDLE on the same cycle.
REQ-018 The framer SHALL treat the first accepted byte as pos and the second as value, then expect pos again.
REQ-019 The gap counter SHALL start at the pos-byte stop sample; if it reaches GAP_TIMEOUT before the next start edge, the held pos byte SHALL be discarded and the framer SHALL expect pos.
REQ-020 A frame_err SHALL also discard any held pos byte and return the framer to expect pos.
REQ-021 A completed pair SHALL load a pending register {pos, value} and set pending.
REQ-022 When pending and busy==0, valid SHALL be high for exactly one cycle, and pending SHALL clear on that cycle.
REQ-023 With busy==0 and nothing pending, valid SHALL rise on the cycle after the value byte's stop sample.
REQ-024 While busy==1, valid SHALL stay low, and pos/value SHALL hold the pending pair.
REQ-025 If a pair completes while pending is set, the new pair SHALL be dropped, overflow SHALL pulse, and the old pair SHALL be kept.
REQ-026 If a pair completes on the same cycle that valid fires, the new pair SHALL become pending with no overflow.
REQ-027 pos and value SHALL change only when the pending register loads.

Reset
REQ-028 RST SHALL force valid=0, pos=0x00, value=0x00, frame_err=0, overflow=0, pending=0, receiver IDLE, framer expect-pos, and all counters to 0.
REQ-029 RST asserted mid-byte or mid-pair SHALL discard all partial data, and no valid SHALL follow from it.
REQ-030 The synchronizer flops SHALL reset to 1 (idle line).

Structure
REQ-031 Shared package pixel_uart_pkg SHALL hold CLKS_PER_BIT, GAP_TIMEOUT, and the receiver state encoding.
REQ-032 Byte reception SHALL live in sub-module uart_rx_byte (synchronizer, 4-state FSM, byte strobe, frame_err); framing, gap timer and pending logic SHALL live in pixel_uart_rx.

Verification
REQ-033 Scenario: busy=0; send 0xC3 then 0x5B back-to-back -> one valid pulse with pos=0xC3, value=0x5B, one cycle after the second stop sample.
REQ-034 Scenario: busy=1 throughout pair 0xFF/0x89, then busy=0 -> valid stays low, then fires exactly once with pos=0xFF, value=0x89.
REQ-035 Scenario: busy=1; send pairs C0/06 then C1/5B; release busy -> overflow pulses once, then a single valid with pos=0xC0, value=0x06.
REQ-036 Scenario: send 0xC2 with stop bit low, then pair C4/7F -> frame_err pulses once, then valid with pos=0xC4, value=0x7F.
REQ-037 Scenario: 20-cycle low glitch on RX -> no strobe and no frame_err; send 0xC5, idle 13000 cycles, then send C6/01 -> valid with pos=0xC6, value=0x01.
REQ-038 Scenario: RST pulsed during the value byte's data bits -> outputs at reset values, no valid; the next pair C7/11 decodes correctly.
